// File: rtl/controller_reciprocal.sv
`default_nettype none
// ============================================================================
// Module      : controller_reciprocal
// Description : Control FSM for a Newton-Raphson reciprocal datapath.
//               Runs r <- r*(2 - x*r) from r0 = 1.0 for a programmable
//               number of iterations, with two handshaked multiplies per
//               iteration. All outputs are registered Moore decodes.
// Revision    : 1.0 - initial release
// ============================================================================
module controller_reciprocal #(
    parameter int N = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [3:0] iters,
    input  logic       ready,
    input  logic [3:0] co,
    output logic       cload,
    output logic       cen,
    output logic       load,
    output logic       start,
    output logic [1:2] s,
    output logic       busy,
    output logic       done
);

    // N only documents the datapath width; reject nonsensical values early.
    if (N < 1) begin : g_width_check
        $error("controller_reciprocal: N must be at least 1");
    end

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INIT      = 4'd1,
        M1_START  = 4'd2,
        M1_SETTLE = 4'd3,
        M1_WAIT   = 4'd4,
        M2_START  = 4'd5,
        M2_SETTLE = 4'd6,
        M2_WAIT   = 4'd7,
        UPDATE    = 4'd8,
        CHECK     = 4'd9,
        DONE      = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] n_iter_q, n_iter_d;

    logic       cload_q, cload_d;
    logic       cen_q, cen_d;
    logic       load_q, load_d;
    logic       start_q, start_d;
    logic [1:2] s_q, s_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next-state logic; the iteration count is captured only on go acceptance.
    always_comb begin
        state_d  = state_q;
        n_iter_d = n_iter_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    // A zero count would never match the counter after its
                    // first increment, so it is promoted to one iteration.
                    n_iter_d = (iters == 4'd0) ? 4'd1 : iters;
                    state_d  = INIT;
                end
            end
            INIT:      state_d = M1_START;
            M1_START:  state_d = M1_SETTLE;
            // SETTLE skips one ready sample so a stale ready from the
            // previous multiply cannot end the phase early.
            M1_SETTLE: state_d = M1_WAIT;
            M1_WAIT:   state_d = ready ? M2_START : M1_WAIT;
            M2_START:  state_d = M2_SETTLE;
            M2_SETTLE: state_d = M2_WAIT;
            M2_WAIT:   state_d = ready ? UPDATE : M2_WAIT;
            UPDATE:    state_d = CHECK;
            // Counter has already been incremented by UPDATE here.
            CHECK:     state_d = (co == n_iter_q) ? DONE : M1_START;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they belong to.
    always_comb begin
        cload_d = 1'b0;
        cen_d   = 1'b0;
        load_d  = 1'b0;
        start_d = 1'b0;
        s_d     = 2'b00;
        done_d  = 1'b0;
        busy_d  = (state_d != IDLE);
        unique case (state_d)
            INIT: begin
                load_d  = 1'b1;
                cload_d = 1'b1;
            end
            M1_START: begin
                s_d     = 2'b01;
                start_d = 1'b1;
            end
            M1_SETTLE, M1_WAIT: s_d = 2'b01;
            M2_START:           start_d = 1'b1;
            UPDATE: begin
                load_d = 1'b1;
                s_d    = 2'b10;
                cen_d  = 1'b1;
            end
            CHECK:   s_d    = 2'b10;
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // State, latched count and registered outputs; reset aborts any run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            n_iter_q <= 4'd1;
            cload_q  <= 1'b0;
            cen_q    <= 1'b0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
            s_q      <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_iter_q <= n_iter_d;
            cload_q  <= cload_d;
            cen_q    <= cen_d;
            load_q   <= load_d;
            start_q  <= start_d;
            s_q      <= s_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cload = cload_q;
    assign cen   = cen_q;
    assign load  = load_q;
    assign start = start_q;
    assign s     = s_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_controller_reciprocal.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller_reciprocal
// Description : Self-checking bench for controller_reciprocal. A multiplier
//               latency model and iteration counter model stand in for the
//               datapath; expected run results are queued at go and checked
//               when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controller_reciprocal;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       go    = 1'b0;
    logic [3:0] iters = 4'd0;
    logic       ready;
    logic [3:0] co    = 4'd0;
    logic       cload, cen, load, start, busy, done;
    logic [1:2] s;

    controller_reciprocal #(.N(8)) dut (
        .clock (clock),
        .reset (reset),
        .go    (go),
        .iters (iters),
        .ready (ready),
        .co    (co),
        .cload (cload),
        .cen   (cen),
        .load  (load),
        .start (start),
        .s     (s),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int done_cyc;
        int starts;
        int cens;
    } exp_t;

    exp_t sb[$];
    int   start_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_cen = 0;
    int   done_cnt = 0;
    int   m_lat = 8;
    bit   stuck = 1'b0;
    int   mcnt  = 0;
    bit   prev_start = 1'b0;
    int   last_c0 = 0;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Multiplier model: ready returns m_lat cycles after the start cycle.
    always @(posedge clock or posedge reset) begin
        if (reset)              mcnt <= 0;
        else if (start)         mcnt <= m_lat - 1;
        else if (mcnt != 0)     mcnt <= mcnt - 1;
    end
    assign ready = stuck ? 1'b1 : (mcnt == 0);

    // Iteration counter model.
    always @(posedge clock) begin
        if (cload)    co <= 4'd0;
        else if (cen) co <= co + 4'd1;
    end

    // Monitor and scoreboard consumer.
    always @(negedge clock) begin
        if (!reset) begin
            if (load && cload) begin
                start_cyc.delete();
                n_cen = 0;
            end
            if (start) begin
                chk("start_width", int'(prev_start), 0);
                start_cyc.push_back(cyc);
                chk("start_s", int'(s), (start_cyc.size() % 2 == 1) ? 1 : 0);
            end
            prev_start = start;
            if (cen) n_cen++;
            if (done) begin
                done_cnt++;
                chk("done_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("start_count", start_cyc.size(), e.starts);
                    chk("cen_count", n_cen, e.cens);
                end
            end
        end else begin
            prev_start = 1'b0;
        end
    end

    function automatic int outs();
        return int'({cload, cen, load, start, s, busy, done});
    endfunction

    // One complete run; returns the go-acceptance cycle through last_c0.
    task automatic run(input int it, input int m, input bit stk,
                       input bit hold_go, input int new_it);
        int n, phase, dc;
        exp_t e;
        n     = (it == 0) ? 1 : it;
        phase = stk ? 3 : m + 1;
        @(negedge clock);
        m_lat = m;
        stuck = stk;
        iters = it[3:0];
        go    = 1'b1;
        last_c0 = cyc;
        e.done_cyc = last_c0 + 2 + n * (2 * phase + 2);
        e.starts   = 2 * n;
        e.cens     = n;
        sb.push_back(e);
        dc = done_cnt;
        @(negedge clock); #1;
        chk("init_load", int'(load), 1);
        chk("init_cload", int'(cload), 1);
        chk("init_s", int'(s), 0);
        chk("init_busy", int'(busy), 1);
        if (!hold_go) go = 1'b0;
        if (new_it >= 0) iters = new_it[3:0];
        for (int k = 0; k < 600 && done_cnt == dc; k++) begin
            @(negedge clock); #1;
        end
        chk("done_seen", done_cnt - dc, 1);
        go = 1'b0;
        @(negedge clock); #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_outs", outs(), 0);
    endtask

    initial begin
        int dc;
        // Reset asserted from time zero; check mid-cycle.
        #23;
        chk("reset_outs", outs(), 0);
        @(negedge clock);
        reset = 1'b0;

        // Single iteration, M=8: starts at t+2 and t+11, done at t+22.
        run(1, 8, 1'b0, 1'b0, -1);
        chk("start1_cyc", start_cyc.size() > 0 ? start_cyc[0] - last_c0 : -1, 2);
        chk("start2_cyc", start_cyc.size() > 1 ? start_cyc[1] - last_c0 : -1, 11);

        // Three iterations: done at t+62.
        run(3, 8, 1'b0, 1'b0, -1);
        // Zero count behaves as one.
        run(0, 8, 1'b0, 1'b0, -1);
        // go held high and iters changed mid-run: still 2 iterations.
        run(2, 8, 1'b0, 1'b1, 5);
        // Other latencies and maximum count.
        run(4, 2, 1'b0, 1'b0, -1);
        run(15, 3, 1'b0, 1'b0, -1);
        // Stuck ready: done at t+10.
        run(1, 8, 1'b1, 1'b0, -1);
        stuck = 1'b0;

        // Abort in M2_WAIT with an asynchronous reset between edges.
        @(negedge clock);
        m_lat = 8;
        iters = 4'd1;
        go    = 1'b1;
        @(negedge clock);
        go = 1'b0;
        repeat (13) @(negedge clock);
        #1;
        chk("m2wait_s", int'(s), 0);
        chk("m2wait_busy", int'(busy), 1);
        dc = done_cnt;
        #2;
        reset = 1'b1;
        #1;
        chk("abort_outs", outs(), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        #1;
        chk("abort_no_done", done_cnt - dc, 0);
        chk("abort_idle", outs(), 0);

        // Restart after abort runs normally.
        run(2, 5, 1'b0, 1'b0, -1);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
